mlblock_config_loader: RTL and testbench
========================================

// Module: mlblock_config_loader
// PURPOSE
//   Drives the serial configuration chain (config_en/config_in/config_out) of one or
//   more cascaded MLBlock tiles from a parallel configuration word. It accepts a word
//   over a valid/ready handshake and shifts it into the chain MSB-first. It captures
//   the bits returned on config_out as readback of the previous chain contents.
//   Optionally it runs a second pass that re-shifts the same word and compares the
//   returned bits, proving the chain holds the intended configuration.
// PARAMETERS
//   CHAIN_LEN  64  total flops in the chain (sum over all tiles); must be >= 2
//   CNT_W      $clog2(CHAIN_LEN)+1  bit-counter width (derived localparam)
// PORTS
//   clk          in   1          clock
//   reset        in   1          synchronous, active-high reset
//   cfg_valid    in   1          request: cfg_word/cfg_verify valid
//   cfg_ready    out  1          loader idle; handshake when cfg_valid&&cfg_ready
//   cfg_word     in   CHAIN_LEN  word to load; bit i ends in chain position i (0 = nearest config_in)
//   cfg_verify   in   1          1: append verify pass after load pass
//   config_en    out  1          chain shift enable (to first tile)
//   config_in    out  1          serial data into chain (to first tile config_in)
//   config_out   in   1          serial data out of chain (from last tile config_out)
//   busy         out  1          a load/verify is in progress
//   done         out  1          one-cycle pulse when the operation completes
//   rd_word      out  CHAIN_LEN  chain contents captured during load pass (previous config)
//   verify_ok    out  1          valid with done; 1 if verify pass matched (1 when cfg_verify=0)
// BEHAVIOUR
//   Reset values: config_en=0, config_in=0, busy=0, done=0, rd_word=0, verify_ok=0,
//   state=IDLE, counter=0; cfg_valid ignored while reset is high.
//   cfg_ready = (state==IDLE). Word and verify flag are latched on the handshake edge.
//   FSM: IDLE -> LOAD on handshake. LOAD -> VERIFY at the last load shift if the latched
//   verify flag is set, else -> DONE. VERIFY -> DONE at the last verify shift. DONE -> IDLE
//   after one cycle.
//   LOAD: config_en=1 for exactly CHAIN_LEN consecutive cycles. Shift k (0..CHAIN_LEN-1)
//   drives config_in = word[CHAIN_LEN-1-k]. In the same cycle, config_out (the chain's
//   pre-edge last flop) is sampled into rd_word[CHAIN_LEN-1-k].
//   VERIFY: starts in the cycle after the last LOAD shift, with no config_en gap.
//   It re-shifts the same word for CHAIN_LEN cycles and compares config_out with
//   word[CHAIN_LEN-1-k]. Any mismatch clears a sticky match flag. The chain ends
//   holding the word again. rd_word is not updated during VERIFY.
//   DONE: config_en=0. done=1 for one cycle. verify_ok = match flag, or 1 if no verify.
//   busy = LOAD|VERIFY|DONE. rd_word and verify_ok hold until the next handshake.
//   Latency: handshake at edge 0. First shift in cycle 1. done in cycle CHAIN_LEN+1
//   without verify, and in cycle 2*CHAIN_LEN+1 with verify. cfg_ready rises the cycle
//   after done. Back-to-back requests are therefore separated by >= 1 idle cycle.
//   config_in=0 whenever config_en=0. The counter wraps to 0 at the end of each pass.
//   cfg_valid/cfg_word changes while busy are ignored.
//   Reset mid-operation: config_en drops at the reset edge and the FSM returns to IDLE.
//   No done pulse. The chain is left partially shifted; software must reload.
//   Shift chain behaviour of the MLBlock is unchanged. This block is its only driver.
// TESTING
//   Bench model: CHAIN_LEN=8 plus an 8-flop shift register on config_en/config_in/config_out.
//   1 Reset, load 8'hA5 no verify -> config_en high cycles 1..8, config_in = 1,0,1,0,0,1,0,1,
//      done in cycle 9, model holds 8'hA5, rd_word=8'h00, verify_ok=1.
//   2 Then load 8'h3C with verify -> rd_word=8'hA5, 16 contiguous config_en cycles,
//      done in cycle 17, verify_ok=1, model=8'h3C.
//   3 Verify with model bit 5 forced stuck-at-0 during pass 2, word 8'hFF ->
//      verify_ok=0 at done.
//   4 cfg_valid held high with changing cfg_word while busy -> no re-accept; cfg_ready=0
//      until the cycle after done, then the current word is accepted.
//   5 Assert reset at shift 3 of a load -> config_en=0, busy=0, cfg_ready=1 next cycle,
//      no done; a subsequent load of 8'h5A completes correctly.
//   6 CHAIN_LEN=2 build, load 2'b10 with verify -> 4 shifts, done in cycle 5, verify_ok=1.

Source files
------------

// File: rtl/mlblock_config_loader.sv
// ---------------------------------------------------------------------------
// mlblock_config_loader
//   Loads a parallel configuration word into the serial configuration chain
//   of one or more cascaded MLBlock tiles. The word is taken on a valid/ready
//   handshake and shifted in MSB-first. The bits that fall out of the chain
//   during that load pass are captured as readback of the previous contents.
//   An optional verify pass re-shifts the same word and checks that every
//   returned bit matches.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   cfg_valid    request strobe (cfg_word / cfg_verify valid)
//   cfg_ready    high while idle; handshake on cfg_valid && cfg_ready
//   cfg_word     word to load, bit i lands in chain position i
//   cfg_verify   append a verify pass after the load pass
//   config_en    chain shift enable
//   config_in    serial data into the chain
//   config_out   serial data returned from the end of the chain
//   busy         operation in progress
//   done         one-cycle completion pulse
//   rd_word      previous chain contents captured during the load pass
//   verify_ok    verify result, valid with done (1 when no verify requested)
// ---------------------------------------------------------------------------
module mlblock_config_loader #(
    parameter int CHAIN_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_word,
    input  logic                 cfg_verify,
    output logic                 config_en,
    output logic                 config_in,
    input  logic                 config_out,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rd_word,
    output logic                 verify_ok
);

    localparam int CNT_W = $clog2(CHAIN_LEN) + 1;
    localparam int IDX_W = $clog2(CHAIN_LEN);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] word_q;
    logic                 verify_q;
    logic                 match_q;

    logic                 shifting;
    logic                 last_shift;
    logic                 exp_bit;
    logic [IDX_W-1:0]     bit_idx;

    // Shift k works on bit CHAIN_LEN-1-k: MSB enters first so it travels
    // furthest and ends in the top chain position.
    assign bit_idx    = IDX_W'(CHAIN_LEN - 1) - cnt[IDX_W-1:0];
    assign shifting   = (state == ST_LOAD) || (state == ST_VERIFY);
    assign last_shift = (cnt == CNT_W'(CHAIN_LEN - 1));
    assign exp_bit    = word_q[bit_idx];

    assign config_en  = shifting;
    assign config_in  = shifting & exp_bit;
    assign cfg_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    // Data capture: the word is only meaningful once a handshake has loaded it
    // and config_in is gated while idle, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && cfg_valid && cfg_ready)
            word_q <= cfg_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            verify_q  <= 1'b0;
            match_q   <= 1'b0;
            rd_word   <= '0;
            verify_ok <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        verify_q <= cfg_verify;
                        match_q  <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // config_out is the pre-edge last flop: the bit being
                    // pushed out by this shift belongs to the old contents.
                    rd_word[bit_idx] <= config_out;
                    if (last_shift) begin
                        cnt <= '0;
                        if (verify_q) begin
                            state <= ST_VERIFY;
                        end else begin
                            verify_ok <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_VERIFY: begin
                    // After a full load the chain returns the word in the
                    // same MSB-first order it is being re-shifted in.
                    if (config_out != exp_bit)
                        match_q <= 1'b0;
                    if (last_shift) begin
                        cnt       <= '0;
                        verify_ok <= match_q & (config_out == exp_bit);
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlblock_config_loader.sv
// ---------------------------------------------------------------------------
// tb_mlblock_config_loader
//   Directed bench for mlblock_config_loader with an 8-flop chain model
//   (plus a 2-flop build driven by its own small chain model).
// ---------------------------------------------------------------------------
module tb_mlblock_config_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_ready, cfg_verify;
    logic [7:0] cfg_word;
    logic       config_en, config_in, config_out;
    logic       busy, done, verify_ok;
    logic [7:0] rd_word;

    logic       cfg_valid2, cfg_ready2, cfg_verify2;
    logic [1:0] cfg_word2;
    logic       config_en2, config_in2, config_out2;
    logic       busy2, done2, verify_ok2;
    logic [1:0] rd_word2;

    logic [7:0] chain  = 8'h00;
    logic [1:0] chain2 = 2'b00;
    logic       stuck  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int         op_done_cyc, op_en_cnt, op_en_first, op_en_last, op_inbad;
    logic [7:0] op_ins;

    always #5 clk = ~clk;

    mlblock_config_loader #(.CHAIN_LEN(8)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_word(cfg_word), .cfg_verify(cfg_verify), .config_en(config_en),
        .config_in(config_in), .config_out(config_out), .busy(busy), .done(done),
        .rd_word(rd_word), .verify_ok(verify_ok)
    );

    mlblock_config_loader #(.CHAIN_LEN(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
        .cfg_word(cfg_word2), .cfg_verify(cfg_verify2), .config_en(config_en2),
        .config_in(config_in2), .config_out(config_out2), .busy(busy2), .done(done2),
        .rd_word(rd_word2), .verify_ok(verify_ok2)
    );

    // Chain models: position 0 nearest config_in, last position drives config_out.
    // Optional stuck-at-0 on position 5 of the 8-flop model.
    assign config_out  = chain[7];
    assign config_out2 = chain2[1];

    always @(posedge clk) begin
        if (config_en)
            chain <= stuck ? ({chain[6:0], config_in} & 8'hDF) : {chain[6:0], config_in};
        if (config_en2)
            chain2 <= {chain2[0], config_in2};
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // One full operation on the 8-flop DUT; cycle 1 is the first cycle after
    // the handshake edge. stuck_req enables the model fault from the first
    // verify shift onwards.
    task automatic do_op(input logic [7:0] w, input logic v, input logic stuck_req);
        op_done_cyc = -1; op_en_cnt = 0; op_en_first = 0; op_en_last = 0;
        op_inbad = 0; op_ins = 8'h00;
        @(negedge clk);
        cfg_word = w; cfg_verify = v; cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (config_en === 1'b1) begin
                op_en_cnt++;
                if (op_en_first == 0) op_en_first = c;
                op_en_last = c;
                if (op_en_cnt <= 8) op_ins = {op_ins[6:0], config_in};
            end else if (config_in !== 1'b0) begin
                op_inbad++;
            end
            if (stuck_req && op_en_cnt == 9) stuck = 1'b1;
            if (done === 1'b1) begin
                op_done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; cfg_valid = 1'b1; cfg_word = 8'hFF; cfg_verify = 1'b0;
        cfg_valid2 = 1'b0; cfg_word2 = 2'b00; cfg_verify2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (config_en !== 1'b0) begin n_bad++; $display("FAIL reset_config_en got %b want 0", config_en); end
        n_cmp++; if (config_in !== 1'b0) begin n_bad++; $display("FAIL reset_config_in got %b want 0", config_in); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (rd_word !== 8'h00) begin n_bad++; $display("FAIL reset_rd_word got %h want 00", rd_word); end
        n_cmp++; if (verify_ok !== 1'b0) begin n_bad++; $display("FAIL reset_verify_ok got %b want 0", verify_ok); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        cfg_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_load_no_verify;
        do_op(8'hA5, 1'b0, 1'b0);
        n_cmp++; if (op_done_cyc != 9) begin n_bad++; $display("FAIL load_done_cycle got %0d want 9", op_done_cyc); end
        n_cmp++; if (op_en_cnt != 8 || op_en_first != 1 || op_en_last != 8) begin n_bad++;
            $display("FAIL load_en_window got cnt=%0d first=%0d last=%0d want 8/1/8", op_en_cnt, op_en_first, op_en_last); end
        n_cmp++; if (op_ins !== 8'hA5) begin n_bad++; $display("FAIL load_config_in_seq got %h want a5", op_ins); end
        n_cmp++; if (op_inbad != 0) begin n_bad++; $display("FAIL load_in_idle got %0d want 0", op_inbad); end
        n_cmp++; if (chain !== 8'hA5) begin n_bad++; $display("FAIL load_chain got %h want a5", chain); end
        n_cmp++; if (rd_word !== 8'h00) begin n_bad++; $display("FAIL load_rd_word got %h want 00", rd_word); end
        n_cmp++; if (verify_ok !== 1'b1) begin n_bad++; $display("FAIL load_verify_ok got %b want 1", verify_ok); end
        n_cmp++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin n_bad++; $display("FAIL load_busy_at_done got busy=%b rdy=%b want 1/0", busy, cfg_ready); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin n_bad++;
            $display("FAIL load_after_done got done=%b rdy=%b busy=%b want 0/1/0", done, cfg_ready, busy); end
    endtask

    task automatic test_load_verify;
        do_op(8'h3C, 1'b1, 1'b0);
        n_cmp++; if (op_done_cyc != 17) begin n_bad++; $display("FAIL verify_done_cycle got %0d want 17", op_done_cyc); end
        n_cmp++; if (op_en_cnt != 16 || op_en_first != 1 || op_en_last != 16) begin n_bad++;
            $display("FAIL verify_en_window got cnt=%0d first=%0d last=%0d want 16/1/16", op_en_cnt, op_en_first, op_en_last); end
        n_cmp++; if (rd_word !== 8'hA5) begin n_bad++; $display("FAIL verify_rd_word got %h want a5", rd_word); end
        n_cmp++; if (verify_ok !== 1'b1) begin n_bad++; $display("FAIL verify_ok got %b want 1", verify_ok); end
        n_cmp++; if (chain !== 8'h3C) begin n_bad++; $display("FAIL verify_chain got %h want 3c", chain); end
        n_cmp++; if (op_inbad != 0) begin n_bad++; $display("FAIL verify_in_idle got %0d want 0", op_inbad); end
    endtask

    task automatic test_verify_fault;
        do_op(8'hFF, 1'b1, 1'b1);
        n_cmp++; if (op_done_cyc != 17) begin n_bad++; $display("FAIL fault_done_cycle got %0d want 17", op_done_cyc); end
        n_cmp++; if (verify_ok !== 1'b0) begin n_bad++; $display("FAIL fault_verify_ok got %b want 0", verify_ok); end
        n_cmp++; if (rd_word !== 8'h3C) begin n_bad++; $display("FAIL fault_rd_word got %h want 3c", rd_word); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int bad_rdy;
        int done_at;
        bad_rdy = 0; done_at = -1;
        @(negedge clk);
        cfg_word = 8'h96; cfg_verify = 1'b0; cfg_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            cfg_word = 8'h10 + 8'(c);
            if (cfg_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
            if (done === 1'b1 && done_at < 0) done_at = c;
        end
        n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL b2b_ready_while_busy got %0d bad cycles want 0", bad_rdy); end
        n_cmp++; if (done_at != 9) begin n_bad++; $display("FAIL b2b_first_done got %0d want 9", done_at); end
        @(negedge clk);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_done got %b want 1", cfg_ready); end
        n_cmp++; if (chain !== 8'h96) begin n_bad++; $display("FAIL b2b_first_chain got %h want 96", chain); end
        cfg_word = 8'h69;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin done_at = c; break; end
            @(negedge clk);
        end
        n_cmp++; if (done_at != 9) begin n_bad++; $display("FAIL b2b_second_done got %0d want 9", done_at); end
        n_cmp++; if (chain !== 8'h69) begin n_bad++; $display("FAIL b2b_second_chain got %h want 69", chain); end
        n_cmp++; if (rd_word !== 8'h96) begin n_bad++; $display("FAIL b2b_second_rd_word got %h want 96", rd_word); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load;
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        cfg_word = 8'hC3; cfg_verify = 1'b0; cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (config_en !== 1'b1) begin n_bad++; $display("FAIL midrst_shifting got %b want 1", config_en); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (config_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin n_bad++;
            $display("FAIL midrst_state got en=%b busy=%b rdy=%b want 0/0/1", config_en, busy, cfg_ready); end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL midrst_no_done got %0d want 0", done_seen); end
        do_op(8'h5A, 1'b0, 1'b0);
        n_cmp++; if (op_done_cyc != 9) begin n_bad++; $display("FAIL midrst_reload_done got %0d want 9", op_done_cyc); end
        n_cmp++; if (chain !== 8'h5A) begin n_bad++; $display("FAIL midrst_reload_chain got %h want 5a", chain); end
        n_cmp++; if (verify_ok !== 1'b1) begin n_bad++; $display("FAIL midrst_reload_ok got %b want 1", verify_ok); end
        @(negedge clk);
    endtask

    task automatic test_chain_len2;
        int en_cnt;
        int done_at;
        en_cnt = 0; done_at = -1;
        @(negedge clk);
        cfg_word2 = 2'b10; cfg_verify2 = 1'b1; cfg_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (config_en2 === 1'b1) en_cnt++;
            if (done2 === 1'b1) begin done_at = c; break; end
            @(negedge clk);
        end
        n_cmp++; if (done_at != 5) begin n_bad++; $display("FAIL len2_done_cycle got %0d want 5", done_at); end
        n_cmp++; if (en_cnt != 4) begin n_bad++; $display("FAIL len2_shifts got %0d want 4", en_cnt); end
        n_cmp++; if (verify_ok2 !== 1'b1) begin n_bad++; $display("FAIL len2_verify_ok got %b want 1", verify_ok2); end
        n_cmp++; if (chain2 !== 2'b10) begin n_bad++; $display("FAIL len2_chain got %b want 10", chain2); end
        n_cmp++; if (rd_word2 !== 2'b00) begin n_bad++; $display("FAIL len2_rd_word got %b want 00", rd_word2); end
    endtask

    initial begin
        test_reset();
        test_load_no_verify();
        test_load_verify();
        test_verify_fault();
        test_back_to_back();
        test_reset_mid_load();
        test_chain_len2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
